// File: rtl/wheel_freq_meter.sv
// Counts filtered rising edges of an asynchronous input over a fixed CLK-derived gate window.
// Each closed window publishes FREQ/OVF with a one-cycle VALID strobe and toggles GATE_O.
module wheel_freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 16,
    parameter int FILTER_LEN  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] FREQ,
    output logic             VALID,
    output logic             OVF,
    output logic             GATE_O
);

    localparam int GCNT_W = $clog2(GATE_CYCLES);
    localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              s1;
    logic              s2;
    logic              filt;
    logic              filt_d;
    logic [STAB_W-1:0] stab;
    logic [GCNT_W-1:0] gcnt;
    logic [CNT_W-1:0]  ev_cnt;
    logic              sat;

    logic              rise;
    logic              terminal;
    logic              at_max;
    logic [CNT_W-1:0]  cnt_next;
    logic              sat_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= SIG_IN;
            s2 <= s1;
        end
    end

    // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt   <= 1'b0;
            stab   <= '0;
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
            if (s2 == filt) begin
                stab <= '0;
            end else if (stab == STAB_LAST) begin
                filt <= s2;
                stab <= '0;
            end else begin
                stab <= stab + STAB_W'(1);
            end
        end
    end

    always_comb begin
        rise     = filt & ~filt_d;
        terminal = (gcnt == GCNT_LAST);
        at_max   = (ev_cnt == CNT_MAX);
        cnt_next = ev_cnt;
        if (rise && !at_max) begin
            cnt_next = ev_cnt + CNT_W'(1);
        end
        sat_next = sat | (rise & at_max);
    end

    // The terminal cycle publishes cnt_next, so an edge landing there closes with its window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gcnt   <= '0;
            ev_cnt <= '0;
            sat    <= 1'b0;
            FREQ   <= '0;
            VALID  <= 1'b0;
            OVF    <= 1'b0;
            GATE_O <= 1'b0;
        end else if (!EN) begin
            gcnt   <= '0;
            ev_cnt <= '0;
            sat    <= 1'b0;
            VALID  <= 1'b0;
        end else if (terminal) begin
            gcnt   <= '0;
            ev_cnt <= '0;
            sat    <= 1'b0;
            FREQ   <= cnt_next;
            OVF    <= sat_next;
            VALID  <= 1'b1;
            GATE_O <= ~GATE_O;
        end else begin
            gcnt   <= gcnt + GCNT_W'(1);
            ev_cnt <= cnt_next;
            sat    <= sat_next;
            VALID  <= 1'b0;
        end
    end

endmodule

// File: doc/wheel_freq_meter.md
# wheel_freq_meter

Measures the pulse rate of an asynchronous digital input, for example a wheel-encoder or Hall sensor on the car, by counting filtered rising edges over a fixed gate window derived from the 100 MHz system clock. Each completed window produces a count result with a one-cycle valid strobe. The block is the consuming counterpart of the team's clock dividers: dividers generate slow periodic signals from CLK, and this block measures them. It feeds speed readout and the obstacle/pilot control logic.

## Interface
- GATE_CYCLES, 100000000: CLK cycles per measurement window (1 s at 100 MHz); must be ≥ 2.
- CNT_W, 16: width of the edge count and result.
- FILTER_LEN, 4: consecutive synchronized samples required before a level change is accepted; must be ≥ 1.

- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  measurement enable, synchronous to CLK.
- SIG_IN  in  1  asynchronous pulse input.
- FREQ  out  CNT_W  rising-edge count of the last completed window.
- VALID  out  1  one-cycle strobe; FREQ/OVF updated this cycle.
- OVF  out  1  last completed window saturated.
- GATE_O  out  1  toggles at every window boundary (debug/LED).

## Operation
- Synchronizer: 2-FF chain on SIG_IN produces s2. No other logic samples SIG_IN.
- Glitch filter: register filt plus a stability counter stab.
  - s2 == filt: stab <= 0.
  - s2 != filt and stab == FILTER_LEN-1: filt <= s2, stab <= 0.
  - s2 != filt otherwise: stab <= stab+1.
  - Any excursion shorter than FILTER_LEN cycles is discarded.
- Edge detect: filt_d <= filt. edge = filt & ~filt_d.
- Gate counter gcnt runs 0..GATE_CYCLES-1 and wraps. The terminal cycle is gcnt == GATE_CYCLES-1.
- Event counter ev_cnt (CNT_W bits) increments on edge and saturates at 2^CNT_W-1. A sticky sat flag is set when an edge arrives while ev_cnt is at maximum.
- On the terminal cycle:
  - FREQ <= ev_cnt + edge, saturated at 2^CNT_W-1. An edge on the terminal cycle belongs to the closing window.
  - OVF <= sat, or saturation caused by that final edge.
  - VALID <= 1. GATE_O <= ~GATE_O.
  - ev_cnt <= 0, sat <= 0.
- EN low:
  - gcnt, ev_cnt and sat are held at 0. VALID = 0. FREQ, OVF and GATE_O hold.
  - Synchronizer and filter keep running, so no false edge occurs on re-enable from a stale filt.
- EN rising: a new window starts with gcnt = 0 on the first cycle EN is sampled high. The first VALID follows exactly GATE_CYCLES cycles later.

## Timing
- Reset values: FREQ = 0, VALID = 0, OVF = 0, GATE_O = 0. Internally sync FFs, filt, filt_d, stab, gcnt, ev_cnt and sat are all 0.
- RST mid-window aborts the window with no VALID. After RST is released with EN high, the first VALID occurs on the GATE_CYCLES-th cycle.
- VALID is registered, high for exactly 1 cycle per window. Consecutive VALIDs are GATE_CYCLES cycles apart.
- Input latency: SIG_IN high first sampled at edge k → filt rises at edge k+1+FILTER_LEN → ev_cnt increments at edge k+2+FILTER_LEN, provided SIG_IN stays high through edge k+FILTER_LEN.
- Maximum countable rate: one edge per 2·FILTER_LEN CLK cycles. Faster input is filtered out, not miscounted.
- Simultaneous edge and terminal cycle: the edge is counted in the closing window, and the new window starts at 0.
- Simultaneous EN falling and terminal cycle: EN low wins, so no VALID is produced and FREQ holds.

## Test plan
All scenarios use GATE_CYCLES = 100 and FILTER_LEN = 2 unless stated otherwise.
- Reset: RST high for 5 cycles with SIG_IN toggling → FREQ = 0, VALID = 0, OVF = 0, GATE_O = 0. After release with EN = 1, the first VALID comes exactly 100 cycles later.
- Steady train: period 10, 50% duty, phase-locked to the window after the first VALID → every following VALID has FREQ = 10, OVF = 0, and GATE_O toggles each time.
- Glitch rejection: 1-cycle high pulses every 5 cycles for a full window → FREQ = 0. Changing to 3-cycle pulses every 8 cycles → FREQ = 12 or 13, stable window to window.
- Overflow: CNT_W = 4 with 20 clean edges in one window → FREQ = 15, OVF = 1. The next window with 3 edges gives FREQ = 3, OVF = 0.
- Enable: EN dropped at gcnt = 50 → no VALID while low, FREQ holds its old value. EN re-raised → VALID after exactly 100 cycles, counting only edges from the new window.
- Boundary edge: align a filtered rising edge to the terminal cycle → it is counted in the closing window's FREQ, and the next window starts from 0.
